// File: rtl/rob_pkg.sv
// Shared ROB definitions: index width, entry count, instruction type codes and the entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rob_pkg;

  localparam int ROB_WIDTH = 3;
  localparam int ROB_SIZE  = 1 << ROB_WIDTH;

  typedef enum logic [1:0] {
    ROB_REG    = 2'd0,
    ROB_BRANCH = 2'd1,
    ROB_STORE  = 2'd2,
    ROB_EXIT   = 2'd3
  } rob_type_e;

  typedef struct packed {
    logic        busy;
    logic        done;
    rob_type_e   typ;
    logic [4:0]  rd;
    logic        pred_taken;
    logic [31:0] alt_pc;
    logic [31:0] value;
  } rob_entry_t;

endpackage

// File: rtl/rob.sv
// Reorder buffer: allocates in decode order, captures RS/LSB broadcasts, retires one entry per cycle in order.
// Latency: entry done at edge N -> commit_* valid after edge N+1; misprediction flush and clear pulse on the commit edge.
// Backpressure: rob_full must gate dec_ready (ignored when full); rdy_in low freezes all state and registered outputs.
//
// Ports: clk_in/rst_n_in/rdy_in; decoder alloc (dec_*, rob_full, rob_tail); result broadcasts (rs_*, lsb_*);
//        operand lookups (qj_*/qk_*); commit interface (commit_*); control (halt, clear, redirect_pc).
module rob
  import rob_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rdy_in,
  output logic                 rob_full,
  output logic [ROB_WIDTH-1:0] rob_tail,
  input  logic                 dec_ready,
  input  logic [1:0]           dec_type,
  input  logic [4:0]           dec_rd,
  input  logic                 dec_pred_taken,
  input  logic [31:0]          dec_alt_pc,
  input  logic                 rs_ready,
  input  logic [ROB_WIDTH-1:0] rs_rob_id,
  input  logic [31:0]          rs_value,
  input  logic                 lsb_ready,
  input  logic [ROB_WIDTH-1:0] lsb_rob_id,
  input  logic [31:0]          lsb_value,
  input  logic [ROB_WIDTH-1:0] qj_id,
  input  logic [ROB_WIDTH-1:0] qk_id,
  output logic                 qj_done,
  output logic                 qk_done,
  output logic [31:0]          qj_value,
  output logic [31:0]          qk_value,
  output logic                 commit_valid,
  output logic [ROB_WIDTH-1:0] commit_rob_id,
  output logic [4:0]           commit_rd,
  output logic [31:0]          commit_value,
  output logic                 commit_store,
  output logic                 halt,
  output logic                 clear,
  output logic [31:0]          redirect_pc
);

  rob_entry_t           r_ent [ROB_SIZE];
  logic [ROB_WIDTH-1:0] r_head;
  logic [ROB_WIDTH-1:0] r_tail;
  logic [ROB_WIDTH:0]   r_count;

  rob_entry_t w_head_ent;
  logic       w_commit;
  logic       w_mispredict;
  logic       w_alloc;
  rob_type_e  w_dec_type;

  assign w_head_ent = r_ent[r_head];
  assign w_dec_type = rob_type_e'(dec_type);

  // Once EXIT has retired nothing else may retire.
  assign w_commit     = !halt && w_head_ent.busy && w_head_ent.done;
  assign w_mispredict = w_commit && (w_head_ent.typ == ROB_BRANCH) &&
                        (w_head_ent.value[0] != w_head_ent.pred_taken);
  // The cycle following a flush still carries wrong-path decode; drop it.
  assign w_alloc      = dec_ready && !rob_full && !clear;

  assign rob_full = (r_count == (ROB_WIDTH+1)'(ROB_SIZE));
  assign rob_tail = r_tail;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < ROB_SIZE; i++) r_ent[i] <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      commit_valid  <= 1'b0;
      commit_rob_id <= '0;
      commit_rd     <= '0;
      commit_value  <= '0;
      commit_store  <= 1'b0;
      halt          <= 1'b0;
      clear         <= 1'b0;
      redirect_pc   <= '0;
    end else if (rdy_in) begin
      commit_valid <= w_commit;
      commit_store <= w_commit && (w_head_ent.typ == ROB_STORE);
      clear        <= 1'b0;

      if (w_commit) begin
        commit_rob_id <= r_head;
        commit_rd     <= (w_head_ent.typ == ROB_REG) ? w_head_ent.rd : 5'd0;
        commit_value  <= w_head_ent.value;
        if (w_head_ent.typ == ROB_EXIT) halt <= 1'b1;
      end

      if (w_mispredict) begin
        // Everything younger than the branch is wrong-path: drop it all.
        for (int i = 0; i < ROB_SIZE; i++) begin
          r_ent[i].busy <= 1'b0;
          r_ent[i].done <= 1'b0;
        end
        r_head      <= '0;
        r_tail      <= '0;
        r_count     <= '0;
        clear       <= 1'b1;
        redirect_pc <= w_head_ent.alt_pc;
      end else begin
        if (!clear) begin
          // LSB write is placed last so it wins a same-id collision.
          if (rs_ready && r_ent[rs_rob_id].busy) begin
            r_ent[rs_rob_id].value <= rs_value;
            r_ent[rs_rob_id].done  <= 1'b1;
          end
          if (lsb_ready && r_ent[lsb_rob_id].busy) begin
            r_ent[lsb_rob_id].value <= lsb_value;
            r_ent[lsb_rob_id].done  <= 1'b1;
          end
        end

        // tail == head with both active cannot happen: that needs count 0 (no commit) or 8 (no alloc).
        if (w_alloc) begin
          r_ent[r_tail].busy       <= 1'b1;
          r_ent[r_tail].done       <= (w_dec_type == ROB_STORE) || (w_dec_type == ROB_EXIT);
          r_ent[r_tail].typ        <= w_dec_type;
          r_ent[r_tail].rd         <= dec_rd;
          r_ent[r_tail].pred_taken <= dec_pred_taken;
          r_ent[r_tail].alt_pc     <= dec_alt_pc;
          r_ent[r_tail].value      <= '0;
          r_tail                   <= r_tail + 1'b1;
        end

        if (w_commit) begin
          r_ent[r_head].busy <= 1'b0;
          r_head             <= r_head + 1'b1;
        end

        r_count <= r_count + {{ROB_WIDTH{1'b0}}, w_alloc} - {{ROB_WIDTH{1'b0}}, w_commit};
      end
    end
  end

  // Operand lookup: same-cycle broadcasts bypass storage, LSB taking priority over RS.
  always_comb begin
    qj_done  = r_ent[qj_id].done;
    qj_value = r_ent[qj_id].value;
    if (rs_ready && (rs_rob_id == qj_id)) begin
      qj_done  = 1'b1;
      qj_value = rs_value;
    end
    if (lsb_ready && (lsb_rob_id == qj_id)) begin
      qj_done  = 1'b1;
      qj_value = lsb_value;
    end

    qk_done  = r_ent[qk_id].done;
    qk_value = r_ent[qk_id].value;
    if (rs_ready && (rs_rob_id == qk_id)) begin
      qk_done  = 1'b1;
      qk_value = rs_value;
    end
    if (lsb_ready && (lsb_rob_id == qk_id)) begin
      qk_done  = 1'b1;
      qk_value = lsb_value;
    end
  end

endmodule

// File: tb/tb_rob.sv
module tb_rob;
  import rob_pkg::*;

  logic                 clk_in = 1'b0;
  logic                 rst_n_in = 1'b1;
  logic                 rdy_in = 1'b1;
  logic                 rob_full;
  logic [ROB_WIDTH-1:0] rob_tail;
  logic                 dec_ready = 1'b0;
  logic [1:0]           dec_type = 2'd0;
  logic [4:0]           dec_rd = '0;
  logic                 dec_pred_taken = 1'b0;
  logic [31:0]          dec_alt_pc = '0;
  logic                 rs_ready = 1'b0;
  logic [ROB_WIDTH-1:0] rs_rob_id = '0;
  logic [31:0]          rs_value = '0;
  logic                 lsb_ready = 1'b0;
  logic [ROB_WIDTH-1:0] lsb_rob_id = '0;
  logic [31:0]          lsb_value = '0;
  logic [ROB_WIDTH-1:0] qj_id = '0;
  logic [ROB_WIDTH-1:0] qk_id = '0;
  logic                 qj_done, qk_done;
  logic [31:0]          qj_value, qk_value;
  logic                 commit_valid;
  logic [ROB_WIDTH-1:0] commit_rob_id;
  logic [4:0]           commit_rd;
  logic [31:0]          commit_value;
  logic                 commit_store;
  logic                 halt;
  logic                 clear;
  logic [31:0]          redirect_pc;

  int tests = 0;
  int fails = 0;

  rob dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .rob_full(rob_full), .rob_tail(rob_tail),
    .dec_ready(dec_ready), .dec_type(dec_type), .dec_rd(dec_rd),
    .dec_pred_taken(dec_pred_taken), .dec_alt_pc(dec_alt_pc),
    .rs_ready(rs_ready), .rs_rob_id(rs_rob_id), .rs_value(rs_value),
    .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
    .qj_id(qj_id), .qk_id(qk_id),
    .qj_done(qj_done), .qk_done(qk_done), .qj_value(qj_value), .qk_value(qk_value),
    .commit_valid(commit_valid), .commit_rob_id(commit_rob_id), .commit_rd(commit_rd),
    .commit_value(commit_value), .commit_store(commit_store),
    .halt(halt), .clear(clear), .redirect_pc(redirect_pc)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic alloc(input logic [1:0] t, input logic [4:0] rd, input logic pred, input logic [31:0] alt);
    dec_type = t; dec_rd = rd; dec_pred_taken = pred; dec_alt_pc = alt;
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
  endtask

  // Mid-cycle async reset pulse.
  task automatic pulse_reset();
    #2 rst_n_in = 1'b0;
    #2 rst_n_in = 1'b1;
  endtask

  initial begin
    // Reset state
    #1 rst_n_in = 1'b0;
    #2;
    check("rst_full", rob_full, 0);
    check("rst_tail", rob_tail, 0);
    check("rst_commit_valid", commit_valid, 0);
    check("rst_halt", halt, 0);
    check("rst_clear", clear, 0);
    check("rst_qj_done", qj_done, 0);
    #9 rst_n_in = 1'b1;

    // Single REG allocate, broadcast, commit
    alloc(ROB_REG, 5'd5, 1'b0, 32'h0);
    check("t1_tail", rob_tail, 1);
    rs_ready = 1'b1; rs_rob_id = 0; rs_value = 32'h1234; qj_id = 0;
    #1;
    check("t1_fwd_done", qj_done, 1);
    check("t1_fwd_value", qj_value, 32'h1234);
    tick();
    rs_ready = 1'b0;
    check("t1_no_commit_yet", commit_valid, 0);
    tick();
    check("t1_commit_valid", commit_valid, 1);
    check("t1_commit_id", commit_rob_id, 0);
    check("t1_commit_rd", commit_rd, 5);
    check("t1_commit_value", commit_value, 32'h1234);
    check("t1_commit_store", commit_store, 0);
    tick();
    check("t1_commit_pulse", commit_valid, 0);

    // Fill to full, overflow ignored, commit then refill
    pulse_reset();
    for (int i = 0; i < 8; i++) alloc(ROB_REG, 5'(i + 1), 1'b0, 32'h0);
    check("t2_full", rob_full, 1);
    check("t2_tail_wrap", rob_tail, 0);
    alloc(ROB_REG, 5'd20, 1'b0, 32'h0);
    check("t2_overflow_tail", rob_tail, 0);
    check("t2_overflow_full", rob_full, 1);
    rs_ready = 1'b1; rs_rob_id = 0; rs_value = 32'h50;
    tick();
    rs_ready = 1'b0;
    dec_type = ROB_REG; dec_rd = 5'd9; dec_ready = 1'b1;
    tick();
    check("t2_commit_valid", commit_valid, 1);
    check("t2_commit_id", commit_rob_id, 0);
    check("t2_commit_value", commit_value, 32'h50);
    check("t2_commit_rd", commit_rd, 1);
    check("t2_blocked_tail", rob_tail, 0);
    check("t2_not_full", rob_full, 0);
    tick();
    dec_ready = 1'b0;
    check("t2_refill_tail", rob_tail, 1);
    check("t2_refill_full", rob_full, 1);
    check("t2_no_commit", commit_valid, 0);

    // Out-of-order completion, in-order retirement, stall hold
    pulse_reset();
    alloc(ROB_REG, 5'd1, 1'b0, 32'h0);
    alloc(ROB_REG, 5'd2, 1'b0, 32'h0);
    alloc(ROB_REG, 5'd3, 1'b0, 32'h0);
    rs_ready = 1'b1; rs_rob_id = 2; rs_value = 32'h22;
    tick();
    check("t3_wait0", commit_valid, 0);
    lsb_ready = 1'b1; lsb_rob_id = 0; lsb_value = 32'h20; rs_ready = 1'b0;
    tick();
    lsb_ready = 1'b0;
    check("t3_wait1", commit_valid, 0);
    rs_ready = 1'b1; rs_rob_id = 1; rs_value = 32'h21;
    tick();
    rs_ready = 1'b0;
    check("t3_c0_valid", commit_valid, 1);
    check("t3_c0_id", commit_rob_id, 0);
    check("t3_c0_value", commit_value, 32'h20);
    tick();
    check("t3_c1_valid", commit_valid, 1);
    check("t3_c1_id", commit_rob_id, 1);
    check("t3_c1_rd", commit_rd, 2);
    rdy_in = 1'b0;
    tick();
    check("t3_stall_valid", commit_valid, 1);
    check("t3_stall_id", commit_rob_id, 1);
    rdy_in = 1'b1;
    tick();
    check("t3_c2_id", commit_rob_id, 2);
    check("t3_c2_value", commit_value, 32'h22);
    tick();
    check("t3_idle", commit_valid, 0);

    // Branch misprediction flush
    pulse_reset();
    alloc(ROB_BRANCH, 5'd0, 1'b1, 32'h100);
    alloc(ROB_REG, 5'd7, 1'b0, 32'h0);
    rs_ready = 1'b1; rs_rob_id = 1; rs_value = 32'h77;
    tick();
    rs_rob_id = 0; rs_value = 32'h0;
    tick();
    rs_ready = 1'b0;
    check("t4_pre_clear", clear, 0);
    tick();
    check("t4_clear", clear, 1);
    check("t4_redirect", redirect_pc, 32'h100);
    check("t4_tail_reset", rob_tail, 0);
    check("t4_branch_commit", commit_valid, 1);
    check("t4_branch_rd", commit_rd, 0);
    dec_type = ROB_REG; dec_rd = 5'd3; dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    check("t4_clear_pulse", clear, 0);
    check("t4_alloc_ignored", rob_tail, 0);
    check("t4_id1_dropped", commit_valid, 0);
    tick();
    check("t4_id1_never", commit_valid, 0);

    // STORE then EXIT: store commits with commit_store, EXIT halts
    alloc(ROB_STORE, 5'd0, 1'b0, 32'h0);
    alloc(ROB_EXIT, 5'd0, 1'b0, 32'h0);
    check("t5_store_commit", commit_valid, 1);
    check("t5_store_flag", commit_store, 1);
    check("t5_store_id", commit_rob_id, 0);
    check("t5_halt_early", halt, 0);
    tick();
    check("t5_exit_commit", commit_valid, 1);
    check("t5_exit_id", commit_rob_id, 1);
    check("t5_halt", halt, 1);
    check("t5_exit_store", commit_store, 0);
    alloc(ROB_STORE, 5'd0, 1'b0, 32'h0);
    tick();
    check("t5_post_halt", commit_valid, 0);
    check("t5_halt_sticky", halt, 1);

    // Lookup forwarding with both broadcasts on different ids
    pulse_reset();
    for (int i = 0; i < 4; i++) alloc(ROB_REG, 5'(i + 1), 1'b0, 32'h0);
    qj_id = 3; qk_id = 2;
    lsb_ready = 1'b1; lsb_rob_id = 3; lsb_value = 32'hAB;
    #1;
    check("t6_qj_done", qj_done, 1);
    check("t6_qj_value", qj_value, 32'hAB);
    check("t6_qk_pending", qk_done, 0);
    rs_ready = 1'b1; rs_rob_id = 2; rs_value = 32'h55;
    #1;
    check("t6_qk_done", qk_done, 1);
    check("t6_qk_value", qk_value, 32'h55);
    tick();
    lsb_ready = 1'b0; rs_ready = 1'b0;
    check("t6_qj_stored", qj_value, 32'hAB);
    check("t6_qj_stored_done", qj_done, 1);
    rs_ready = 1'b1; rs_rob_id = 0; rs_value = 32'h10;
    tick();
    rs_ready = 1'b0;
    tick();
    check("t6_commit0", commit_valid, 1);

    // Async reset between edges with entries busy
    #2 rst_n_in = 1'b0;
    #1;
    check("t7_rst_commit_valid", commit_valid, 0);
    check("t7_rst_tail", rob_tail, 0);
    check("t7_rst_qj_done", qj_done, 0);
    check("t7_rst_commit_value", commit_value, 0);
    #2 rst_n_in = 1'b1;
    alloc(ROB_REG, 5'd6, 1'b0, 32'h0);
    check("t7_first_alloc", rob_tail, 1);
    check("t7_no_commit", commit_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
